rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_BIT, default `ROB_BIT from the shared constants file (4), log2 of entry count (16 entries).
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 rdy_in  input  1  ready; when low, all state frozen and rob_commit/rob_clear_up held 0.
REQ-005 issue_valid  input  1  decoder issues one instruction this cycle.
REQ-006 issue_reg_id  input  5  destination register; 0 = no destination.
REQ-007 issue_is_branch  input  1  entry may mispredict.
REQ-008 issue_rob_entry  output  ROB_BIT  tail index the next issue receives (combinational).
REQ-009 rob_full  output  1  all entries busy (combinational).
REQ-010 wb_valid, wb_rob_entry[ROB_BIT], wb_value[32], wb_mispredict[1], wb_target_pc[32]  inputs  execution-unit writeback.
REQ-011 get_rob_entry1/2  input  ROB_BIT  register-file dependency query.
REQ-012 ready1/2  output  1, value1/2  output  32  query responses (combinational).
REQ-013 rob_commit  output  1; commit_reg_id  output  5; commit_reg_data  output  32; commit_rob_entry  output  ROB_BIT  registered commit pulse.
REQ-014 rob_clear_up  output  1; clear_pc  output  32  registered flush pulse with redirect PC.

Function
REQ-015 Entries form a circular buffer: head, tail (ROB_BIT bits, wrap modulo 2^ROB_BIT) and count (ROB_BIT+1 bits).
REQ-016 issue_valid && !rob_full && !rob_clear_up: entry[tail] <= busy=1, ready=0, reg_id, is_branch; tail+1; count+1.
REQ-017 issue_valid while rob_full SHALL be ignored, no state change.
REQ-018 wb_valid to a busy entry sets ready=1, stores wb_value, mispredict, target_pc; writeback to a non-busy entry ignored.
REQ-019 Commit: when count>0 and entry[head] ready, next cycle rob_commit=1 with head's reg_id/value/index; head+1; count-1; entry busy cleared; at most one commit per cycle.
REQ-020 Entry written back in cycle N SHALL commit no earlier than edge N+1 (ready stored first, no wb-to-commit bypass).
REQ-021 Committing entry with mispredict=1: rob_clear_up=1 and clear_pc=target_pc in the same cycle as rob_commit (commit still reports its reg write); then head=tail=count=0, all busy/ready cleared.
REQ-022 During the cycle rob_clear_up is high, issue and writeback inputs SHALL be ignored.
REQ-023 Simultaneous issue and commit: count unchanged, both pointers advance.
REQ-024 Query: readyK = entry ready, or wb_valid && wb_rob_entry==get_rob_entryK (bypass); valueK = wb_value on bypass, else stored value.
REQ-025 rob_commit, rob_clear_up are one-cycle pulses, 0 in any cycle without a commit/flush.
REQ-026 rob_full = (count == 2^ROB_BIT); empty ROB never commits.

Reset
REQ-027 On rst_in low, immediately: head, tail, count 0; all busy/ready/mispredict 0; rob_commit, rob_clear_up 0; commit_reg_id, commit_reg_data, commit_rob_entry, clear_pc 0.
REQ-028 Reset asserted mid-operation discards all in-flight entries; first issue after release receives index 0.

Structure
REQ-029 ROB_BIT and the entry-count derivation live in the shared constants file, used by rob and the register file.
REQ-030 Query bypass logic SHALL be one sub-module rob_query, instantiated twice (ports 1 and 2).

Verification
REQ-031 Reset, issue reg 5 (idx0); wb idx0 value 0x1234 -> next cycle rob_commit=1, commit_reg_id=5, data 0x1234, entry 0.
REQ-032 Issue 16 entries -> rob_full=1; 17th issue ignored; commit one while issuing -> count stays 16, tail wraps to 0.
REQ-033 Query idx3 while wb_valid to idx3 value 0xAA -> ready1=1, value1=0xAA same cycle.
REQ-034 Branch at idx2 wb mispredict target 0x100, idx3-5 issued -> commit of idx2 with rob_clear_up=1, clear_pc=0x100; next issue gets index 0.
REQ-035 Out-of-order wb (idx1 before idx0) -> commits strictly idx0 then idx1, in consecutive cycles.
REQ-036 rdy_in low for 3 cycles with head ready -> no commit until rdy_in returns; rst_in low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and types, also used by the register file.
package rob_pkg;

    // log2 of the reorder-buffer depth
    localparam int ROB_BIT  = 4;
    localparam int REG_ID_W = 5;
    localparam int XLEN     = 32;

    typedef logic [XLEN-1:0]     word_t;
    typedef logic [REG_ID_W-1:0] reg_id_t;

    // Entry count derived from the index width
    function automatic int rob_size(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/rob_query.sv
// One register-file dependency lookup into the reorder buffer, with writeback forwarding.
module rob_query #(
    parameter int   ROB_BIT  = rob_pkg::ROB_BIT,
    localparam int  ROB_SIZE = rob_pkg::rob_size(ROB_BIT)
) (
    input  logic [ROB_BIT-1:0]             get_rob_entry,
    input  logic [ROB_SIZE-1:0]            entry_ready,
    input  logic [ROB_SIZE-1:0][31:0]      entry_value,
    input  logic                           wb_valid,
    input  logic [ROB_BIT-1:0]             wb_rob_entry,
    input  logic [31:0]                    wb_value,
    output logic                           query_ready,
    output logic [31:0]                    query_value
);
    import rob_pkg::*;

    logic  hit;
    word_t stored_value;

    // A writeback landing this cycle is forwarded so the consumer need not wait for the store
    always_comb begin
        hit          = wb_valid && (wb_rob_entry == get_rob_entry);
        stored_value = entry_value[get_rob_entry];
        query_ready  = hit || entry_ready[get_rob_entry];
        query_value  = hit ? wb_value : stored_value;
    end

endmodule

// File: rtl/rob.sv
// Circular reorder buffer: in-order issue, out-of-order writeback, in-order commit with flush.
module rob #(
    parameter int  ROB_BIT  = rob_pkg::ROB_BIT,
    localparam int ROB_SIZE = rob_pkg::rob_size(ROB_BIT)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    input  logic [4:0]         issue_reg_id,
    input  logic               issue_is_branch,
    output logic [ROB_BIT-1:0] issue_rob_entry,
    output logic               rob_full,
    input  logic               wb_valid,
    input  logic [ROB_BIT-1:0] wb_rob_entry,
    input  logic [31:0]        wb_value,
    input  logic               wb_mispredict,
    input  logic [31:0]        wb_target_pc,
    input  logic [ROB_BIT-1:0] get_rob_entry1,
    input  logic [ROB_BIT-1:0] get_rob_entry2,
    output logic               ready1,
    output logic [31:0]        value1,
    output logic               ready2,
    output logic [31:0]        value2,
    output logic               rob_commit,
    output logic [4:0]         commit_reg_id,
    output logic [31:0]        commit_reg_data,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc
);
    import rob_pkg::*;

    localparam logic [ROB_BIT:0]   FULL_COUNT = (ROB_BIT+1)'(ROB_SIZE);
    localparam logic [ROB_BIT:0]   CNT_ONE    = (ROB_BIT+1)'(1);
    localparam logic [ROB_BIT-1:0] PTR_ONE    = ROB_BIT'(1);

    logic [ROB_BIT-1:0] head;
    logic [ROB_BIT-1:0] tail;
    logic [ROB_BIT:0]   count;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] mispredict;
    logic [ROB_SIZE-1:0] is_branch;

    reg_id_t [ROB_SIZE-1:0] reg_id;
    word_t   [ROB_SIZE-1:0] value;
    word_t   [ROB_SIZE-1:0] target_pc;

    logic issue_fire_p0;
    logic wb_fire_p0;
    logic commit_fire_p0;
    logic flush_p0;

    assign issue_rob_entry = tail;
    assign rob_full        = (count == FULL_COUNT);

    // Stage p0: decide which of issue / writeback / commit / flush happen at this edge
    always_comb begin
        issue_fire_p0  = rdy_in && issue_valid && !rob_full && !rob_clear_up;
        wb_fire_p0     = rdy_in && wb_valid && !rob_clear_up && busy[wb_rob_entry];
        commit_fire_p0 = rdy_in && (count != '0) && ready[head];
        flush_p0       = commit_fire_p0 && mispredict[head];
    end

    // Stage p0 -> outputs: pointers, per-entry flags and the registered commit/flush pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            mispredict       <= '0;
            rob_commit       <= 1'b0;
            rob_clear_up     <= 1'b0;
            commit_reg_id    <= '0;
            commit_reg_data  <= '0;
            commit_rob_entry <= '0;
            clear_pc         <= '0;
        end else begin
            rob_commit   <= commit_fire_p0;
            rob_clear_up <= flush_p0;
            if (commit_fire_p0) begin
                commit_reg_id    <= reg_id[head];
                commit_reg_data  <= value[head];
                commit_rob_entry <= head;
            end
            if (flush_p0) begin
                clear_pc   <= target_pc[head];
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                busy       <= '0;
                ready      <= '0;
                mispredict <= '0;
            end else begin
                if (issue_fire_p0) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    mispredict[tail] <= 1'b0;
                    tail             <= tail + PTR_ONE;
                end
                if (wb_fire_p0) begin
                    ready[wb_rob_entry]      <= 1'b1;
                    mispredict[wb_rob_entry] <= wb_mispredict && is_branch[wb_rob_entry];
                end
                if (commit_fire_p0) begin
                    busy[head]       <= 1'b0;
                    ready[head]      <= 1'b0;
                    mispredict[head] <= 1'b0;
                    head             <= head + PTR_ONE;
                end
                unique case ({issue_fire_p0, commit_fire_p0})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    // Entry payloads; only ever read once busy/ready qualify them, so they carry no reset
    always_ff @(posedge clk_in) begin
        if (issue_fire_p0) begin
            reg_id[tail]    <= issue_reg_id;
            is_branch[tail] <= issue_is_branch;
        end
        if (wb_fire_p0) begin
            value[wb_rob_entry]     <= wb_value;
            target_pc[wb_rob_entry] <= wb_target_pc;
        end
    end

    rob_query #(.ROB_BIT(ROB_BIT)) u_query1 (
        .get_rob_entry (get_rob_entry1),
        .entry_ready   (ready),
        .entry_value   (value),
        .wb_valid      (wb_valid),
        .wb_rob_entry  (wb_rob_entry),
        .wb_value      (wb_value),
        .query_ready   (ready1),
        .query_value   (value1)
    );

    rob_query #(.ROB_BIT(ROB_BIT)) u_query2 (
        .get_rob_entry (get_rob_entry2),
        .entry_ready   (ready),
        .entry_value   (value),
        .wb_valid      (wb_valid),
        .wb_rob_entry  (wb_rob_entry),
        .wb_value      (wb_value),
        .query_ready   (ready2),
        .query_value   (value2)
    );

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer: directed stimulus, expected commits queued with their cycle.
module tb_rob;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg_id = '0;
    logic        issue_is_branch = 1'b0;
    logic [3:0]  issue_rob_entry;
    logic        rob_full;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rob_entry = '0;
    logic [31:0] wb_value = '0;
    logic        wb_mispredict = 1'b0;
    logic [31:0] wb_target_pc = '0;
    logic [3:0]  get_rob_entry1 = '0;
    logic [3:0]  get_rob_entry2 = '0;
    logic        ready1, ready2;
    logic [31:0] value1, value2;
    logic        rob_commit;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_reg_data;
    logic [3:0]  commit_rob_entry;
    logic        rob_clear_up;
    logic [31:0] clear_pc;

    rob #(.ROB_BIT(4)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .issue_valid      (issue_valid),
        .issue_reg_id     (issue_reg_id),
        .issue_is_branch  (issue_is_branch),
        .issue_rob_entry  (issue_rob_entry),
        .rob_full         (rob_full),
        .wb_valid         (wb_valid),
        .wb_rob_entry     (wb_rob_entry),
        .wb_value         (wb_value),
        .wb_mispredict    (wb_mispredict),
        .wb_target_pc     (wb_target_pc),
        .get_rob_entry1   (get_rob_entry1),
        .get_rob_entry2   (get_rob_entry2),
        .ready1           (ready1),
        .value1           (value1),
        .ready2           (ready2),
        .value2           (value2),
        .rob_commit       (rob_commit),
        .commit_reg_id    (commit_reg_id),
        .commit_reg_data  (commit_reg_data),
        .commit_rob_entry (commit_rob_entry),
        .rob_clear_up     (rob_clear_up),
        .clear_pc         (clear_pc)
    );

    typedef struct {
        logic [4:0]  rid;
        logic [31:0] data;
        logic [3:0]  ent;
        logic        clr;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] rid, input logic [31:0] data, input logic [3:0] ent,
                            input logic clr, input logic [31:0] pc, input int c);
        exp_t e;
        e.rid = rid; e.data = data; e.ent = ent; e.clr = clr; e.pc = pc; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_issue(input logic [4:0] rid, input logic br);
        issue_valid = 1'b1; issue_reg_id = rid; issue_is_branch = br;
        tick();
        issue_valid = 1'b0; issue_is_branch = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] ent, input logic [31:0] val, input logic mp, input logic [31:0] pc);
        wb_valid = 1'b1; wb_rob_entry = ent; wb_value = val; wb_mispredict = mp; wb_target_pc = pc;
        tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0; wb_valid = 1'b0; rdy_in = 1'b1;
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_commit"},      32'(rob_commit),       32'd0);
        chk({tag, "_clear_up"},    32'(rob_clear_up),     32'd0);
        chk({tag, "_reg_id"},      32'(commit_reg_id),    32'd0);
        chk({tag, "_reg_data"},    commit_reg_data,       32'd0);
        chk({tag, "_rob_entry"},   32'(commit_rob_entry), 32'd0);
        chk({tag, "_clear_pc"},    clear_pc,              32'd0);
        chk({tag, "_full"},        32'(rob_full),         32'd0);
        chk({tag, "_issue_entry"}, 32'(issue_rob_entry),  32'd0);
    endtask

    // Monitor: every commit pulse is matched against the oldest queued expectation
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (rob_commit) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_commit: entry %0d reg %0d at cycle %0d, expected none",
                             commit_rob_entry, commit_reg_id, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("commit_cycle",    32'(cyc),              32'(mon_e.cyc));
                    chk("commit_reg_id",   32'(commit_reg_id),    32'(mon_e.rid));
                    chk("commit_reg_data", commit_reg_data,       mon_e.data);
                    chk("commit_entry",    32'(commit_rob_entry), 32'(mon_e.ent));
                    chk("commit_clear_up", 32'(rob_clear_up),     32'(mon_e.clr));
                    if (mon_e.clr) chk("clear_pc", clear_pc, mon_e.pc);
                end
            end else if (rob_clear_up) begin
                n_cmp++; n_err++;
                $display("FAIL lone_clear_up: rob_clear_up=1 without rob_commit at cycle %0d, expected 0", cyc);
            end
        end
    end

    initial begin
        // Reset state
        #2 rst_in = 1'b0;
        #1 chk_outputs_zero("reset");
        tick();
        tick();
        rst_in = 1'b1;

        // Single issue and writeback
        chk("first_issue_entry", 32'(issue_rob_entry), 32'd0);
        do_issue(5'd5, 1'b0);
        n = cyc;
        push_exp(5'd5, 32'h1234, 4'd0, 1'b0, 32'd0, n + 2);
        do_wb(4'd0, 32'h1234, 1'b0, 32'd0);
        repeat (3) tick();

        // Query with writeback forwarding
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(5'(i + 1), 1'b0);
        get_rob_entry1 = 4'd3; get_rob_entry2 = 4'd2;
        #1 chk("q1_not_ready", 32'(ready1), 32'd0);
        wb_valid = 1'b1; wb_rob_entry = 4'd3; wb_value = 32'hAA; wb_mispredict = 1'b0; wb_target_pc = 32'd0;
        #1;
        chk("q1_bypass_ready", 32'(ready1), 32'd1);
        chk("q1_bypass_value", value1, 32'hAA);
        chk("q2_other_ready",  32'(ready2), 32'd0);
        tick();
        wb_valid = 1'b0; get_rob_entry2 = 4'd3;
        #1;
        chk("q1_stored_ready", 32'(ready1), 32'd1);
        chk("q1_stored_value", value1, 32'hAA);
        chk("q2_stored_value", value2, 32'hAA);
        n = cyc;
        push_exp(5'd1, 32'h1A, 4'd0, 1'b0, 32'd0, n + 2);
        push_exp(5'd2, 32'h2B, 4'd1, 1'b0, 32'd0, n + 3);
        push_exp(5'd3, 32'h3C, 4'd2, 1'b0, 32'd0, n + 4);
        push_exp(5'd4, 32'hAA, 4'd3, 1'b0, 32'd0, n + 5);
        do_wb(4'd0, 32'h1A, 1'b0, 32'd0);
        do_wb(4'd1, 32'h2B, 1'b0, 32'd0);
        do_wb(4'd2, 32'h3C, 1'b0, 32'd0);
        repeat (4) tick();

        // Out-of-order writeback still commits in order
        do_reset();
        do_issue(5'd7, 1'b0);
        do_issue(5'd8, 1'b0);
        n = cyc;
        push_exp(5'd7, 32'h10, 4'd0, 1'b0, 32'd0, n + 3);
        push_exp(5'd8, 32'h11, 4'd1, 1'b0, 32'd0, n + 4);
        do_wb(4'd1, 32'h11, 1'b0, 32'd0);
        do_wb(4'd0, 32'h10, 1'b0, 32'd0);
        repeat (4) tick();

        // Full buffer, ignored issue, simultaneous issue and commit
        do_reset();
        for (int i = 0; i < 16; i++) do_issue(5'(i + 1), 1'b0);
        chk("full_after_16", 32'(rob_full), 32'd1);
        chk("tail_wrapped",  32'(issue_rob_entry), 32'd0);
        do_issue(5'd20, 1'b0);
        chk("full_after_17", 32'(rob_full), 32'd1);
        chk("tail_after_17", 32'(issue_rob_entry), 32'd0);
        n = cyc;
        push_exp(5'd1, 32'hA0, 4'd0, 1'b0, 32'd0, n + 2);
        push_exp(5'd2, 32'hA1, 4'd1, 1'b0, 32'd0, n + 3);
        do_wb(4'd0, 32'hA0, 1'b0, 32'd0);
        chk("full_before_commit", 32'(rob_full), 32'd1);
        do_wb(4'd1, 32'hA1, 1'b0, 32'd0);
        chk("not_full_after_commit", 32'(rob_full), 32'd0);
        do_issue(5'd21, 1'b0);
        chk("not_full_issue_commit", 32'(rob_full), 32'd0);
        chk("tail_issue_commit",     32'(issue_rob_entry), 32'd1);
        do_issue(5'd22, 1'b0);
        chk("full_again",            32'(rob_full), 32'd1);
        chk("tail_full_again",       32'(issue_rob_entry), 32'd2);

        // rdy_in low freezes commit and issue
        do_reset();
        do_issue(5'd12, 1'b0);
        n = cyc;
        push_exp(5'd12, 32'hBEEF, 4'd0, 1'b0, 32'd0, n + 5);
        do_wb(4'd0, 32'hBEEF, 1'b0, 32'd0);
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_reg_id = 5'd13;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_commit", 32'(rob_commit), 32'd0);
        end
        chk("stall_tail_frozen", 32'(issue_rob_entry), 32'd1);
        rdy_in = 1'b1; issue_valid = 1'b0;
        repeat (3) tick();

        // Mispredicted branch flushes younger entries
        do_reset();
        do_issue(5'd1, 1'b0);
        do_issue(5'd2, 1'b0);
        do_issue(5'd3, 1'b1);
        do_issue(5'd4, 1'b0);
        do_issue(5'd5, 1'b0);
        do_issue(5'd6, 1'b0);
        n = cyc;
        push_exp(5'd1, 32'h10, 4'd0, 1'b0, 32'd0,   n + 2);
        push_exp(5'd2, 32'h20, 4'd1, 1'b0, 32'd0,   n + 3);
        push_exp(5'd3, 32'h30, 4'd2, 1'b1, 32'h100, n + 4);
        do_wb(4'd0, 32'h10, 1'b0, 32'd0);
        do_wb(4'd1, 32'h20, 1'b0, 32'd0);
        do_wb(4'd2, 32'h30, 1'b1, 32'h100);
        do_wb(4'd3, 32'h40, 1'b0, 32'd0);
        do_issue(5'd9, 1'b0);
        chk("issue_during_flush_ignored", 32'(issue_rob_entry), 32'd0);
        do_issue(5'd10, 1'b0);
        n = cyc;
        push_exp(5'd10, 32'h55, 4'd0, 1'b0, 32'd0, n + 2);
        do_wb(4'd0, 32'h55, 1'b0, 32'd0);
        repeat (3) tick();

        // Reset mid-run discards everything and clears outputs at once
        do_issue(5'd9, 1'b0);
        do_issue(5'd14, 1'b0);
        do_wb(4'd1, 32'h77, 1'b0, 32'd0);
        tick();
        chk("pre_reset_commit", 32'(rob_commit), 32'd1);
        chk("pre_reset_data",   commit_reg_data, 32'h77);
        rst_in = 1'b0;
        #1 chk_outputs_zero("async_reset");
        tick();
        rst_in = 1'b1;
        tick();
        chk("post_reset_entry", 32'(issue_rob_entry), 32'd0);
        do_issue(5'd3, 1'b0);
        n = cyc;
        push_exp(5'd3, 32'h99, 4'd0, 1'b0, 32'd0, n + 2);
        do_wb(4'd0, 32'h99, 1'b0, 32'd0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
